bus_rx_fifo: RTL and testbench

Receive-side terminal for the bus driver: one instance per bus port absorbs the `push`/`D_push` handshake the bus emits toward a terminal and buffers packets in a first-word-fall-through FIFO. The FIFO is drained by a local consumer through a `pop`/`pndng`/`D_pop` interface. The block also counts dropped and misrouted packets, so the scoreboard and the monitor can read drop and routing health without inferring it. It is the counterpart of the transmit FIFOs that feed the bus through `pndng`/`pop`/`D_pop`.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/sat_cnt16.sv | 31 +++
 rtl/bus_rx_fifo.sv | 102 ++++++++++
 tb/tb_bus_rx_fifo.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus packet definitions: destination ID field and broadcast address.
package bus_pkg;

    localparam int unsigned ID_W     = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
    localparam int unsigned MAX_W    = 64;
    localparam int unsigned PAYLOAD_W = 8;

    // Default 16-bit packet layout; wider users slice the top ID_W bits the same way.
    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_t;

    function automatic logic [ID_W-1:0] dest_of(input logic [MAX_W-1:0] pkt,
                                                input int unsigned w);
        logic [MAX_W-1:0] shifted;
        shifted = pkt >> (w - ID_W);
        return shifted[ID_W-1:0];
    endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at all-ones.
// Latency: q reflects an inc one edge later.
// Backpressure: none; inc is sampled every cycle.
module sat_cnt16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc && (q_q != 16'hFFFF)) begin
            q_d = q_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bus_rx_fifo.sv
// Receive-side FWFT FIFO for one bus port, with drop and misroute counters.
// Latency: a push is visible on D_pop one edge later; pops advance D_pop at the edge.
// Backpressure: none toward the bus; pushes arriving while full with no pop are dropped and counted.
module bus_rx_fifo
    import bus_pkg::*;
#(
    parameter int unsigned     width    = 16,
    parameter int unsigned     depth    = 8,
    parameter logic [ID_W-1:0] my_id    = 8'd0,
    parameter logic [ID_W-1:0] bcast_id = BCAST_ID
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [width-1:0]         D_push,
    input  logic                     pop,
    output logic [width-1:0]         D_pop,
    output logic                     pndng,
    output logic                     full,
    output logic [$clog2(depth):0]   count,
    output logic [15:0]              overflow_cnt,
    output logic [15:0]              misroute_cnt
);

    localparam int unsigned PW = $clog2(depth);
    localparam int unsigned CW = PW + 1;

    logic [width-1:0] mem_q [depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             pop_eff;
    logic             push_acc;
    logic             push_drop;
    logic             misroute;
    logic [ID_W-1:0]  dest;

    // Status comes only from the registered count, so push/pop never reach pndng/full.
    assign pndng = (count_q != '0);
    assign full  = (count_q == CW'(depth));

    assign pop_eff   = pop & pndng & ~reset;
    assign push_acc  = push & ~reset & (~full | pop_eff);
    assign push_drop = push & ~reset & ~push_acc;
    assign dest      = dest_of(MAX_W'(D_push), width);
    assign misroute  = push_acc & (dest != my_id) & (dest != bcast_id);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_acc, pop_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= D_push;
        end
    end

    assign D_pop = reset ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

    sat_cnt16 u_overflow_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (push_drop),
        .q     (overflow_cnt)
    );

    sat_cnt16 u_misroute_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (misroute),
        .q     (misroute_cnt)
    );

endmodule

// File: tb/tb_bus_rx_fifo.sv
// Directed bench for bus_rx_fifo (width 16, depth 8, my_id 1).
module tb_bus_rx_fifo;

    logic        clk;
    logic        reset;
    logic        push;
    logic [15:0] d_push;
    logic        pop;
    logic [15:0] d_pop;
    logic        pndng;
    logic        full;
    logic [3:0]  count;
    logic [15:0] overflow_cnt;
    logic [15:0] misroute_cnt;

    int errors = 0;
    int checks = 0;

    bus_rx_fifo #(
        .width    (16),
        .depth    (8),
        .my_id    (8'h01),
        .bcast_id (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .D_push       (d_push),
        .pop          (pop),
        .D_pop        (d_pop),
        .pndng        (pndng),
        .full         (full),
        .count        (count),
        .overflow_cnt (overflow_cnt),
        .misroute_cnt (misroute_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic ps, input logic [15:0] d, input logic pp);
        push   = ps;
        d_push = d;
        pop    = pp;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] exp);
        chk(tag, {31'd0, pndng}, 32'd1);
        chk(tag, {16'd0, d_pop}, {16'd0, exp});
        step(1'b0, 16'h0000, 1'b1);
    endtask

    initial begin
        reset  = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        d_push = 16'h0000;

        // Reset state, with D_pop forced to zero while reset is high
        step(1'b1, 16'h01AB, 1'b0);
        chk("rst_dpop", {16'd0, d_pop}, 32'd0);
        step(1'b0, 16'h0000, 1'b0);
        reset = 1'b0;
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_pndng", {31'd0, pndng}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {16'd0, overflow_cnt}, 32'd0);
        chk("rst_mis", {16'd0, misroute_cnt}, 32'd0);

        // Three packets; IDs 02 and 03 are misrouted but still stored
        step(1'b1, 16'h0111, 1'b0);
        chk("lat1_pndng", {31'd0, pndng}, 32'd1);
        chk("lat1_dpop", {16'd0, d_pop}, 32'h0111);
        step(1'b1, 16'h0222, 1'b0);
        step(1'b1, 16'h0333, 1'b0);
        chk("t1_count", {28'd0, count}, 32'd3);
        chk("t1_mis", {16'd0, misroute_cnt}, 32'd2);
        pop_expect("t1_p0", 16'h0111);
        pop_expect("t1_p1", 16'h0222);
        pop_expect("t1_p2", 16'h0333);
        chk("t1_empty", {31'd0, pndng}, 32'd0);
        chk("t1_count0", {28'd0, count}, 32'd0);

        // Fill to full, two dropped pushes
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
        chk("t2_full7", {31'd0, full}, 32'd1);
        step(1'b1, 16'h01A0, 1'b0);
        step(1'b1, 16'h01A1, 1'b0);
        chk("t2_full", {31'd0, full}, 32'd1);
        chk("t2_count", {28'd0, count}, 32'd8);
        chk("t2_ovf", {16'd0, overflow_cnt}, 32'd2);
        chk("t2_mis", {16'd0, misroute_cnt}, 32'd2);

        // Push+pop at full: accepted, no drop, broadcast not misrouted
        chk("t3_head", {16'd0, d_pop}, 32'h0100);
        step(1'b1, 16'hFFAA, 1'b1);
        chk("t3_count", {28'd0, count}, 32'd8);
        chk("t3_ovf", {16'd0, overflow_cnt}, 32'd2);
        chk("t3_mis", {16'd0, misroute_cnt}, 32'd2);
        for (int i = 1; i < 8; i++) pop_expect("t3_drain", 16'h0100 + 16'(i));
        pop_expect("t3_last", 16'hFFAA);
        chk("t3_empty", {31'd0, pndng}, 32'd0);

        // Pops on empty are ignored; push+pop on empty stores the packet
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1);
        chk("t4_count0", {28'd0, count}, 32'd0);
        step(1'b1, 16'h0155, 1'b1);
        chk("t4_count1", {28'd0, count}, 32'd1);
        chk("t4_dpop", {16'd0, d_pop}, 32'h0155);
        for (int i = 0; i < 7; i++) step(1'b1, 16'h0160 + 16'(i), 1'b0);
        chk("t4_full", {31'd0, full}, 32'd1);
        chk("t4_ovf", {16'd0, overflow_cnt}, 32'd2);
        pop_expect("t4_head", 16'h0155);
        for (int i = 0; i < 7; i++) pop_expect("t4_drain", 16'h0160 + 16'(i));
        chk("t4_empty", {28'd0, count}, 32'd0);

        // Continuous push+pop across pointer wrap with one entry preloaded
        step(1'b1, 16'h0170, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("t5_dpop", {16'd0, d_pop}, (i == 0) ? 32'h0170 : 32'h0180 + 32'(i - 1));
            step(1'b1, 16'h0180 + 16'(i), 1'b1);
            chk("t5_count", {28'd0, count}, 32'd1);
        end
        pop_expect("t5_tail", 16'h0193);
        chk("t5_mis", {16'd0, misroute_cnt}, 32'd2);

        // Reset with 5 entries and a concurrent push
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0101 + 16'(i), 1'b0);
        chk("t6_pre", {28'd0, count}, 32'd5);
        reset = 1'b1;
        step(1'b1, 16'h01EE, 1'b0);
        reset = 1'b0;
        chk("t6_count", {28'd0, count}, 32'd0);
        chk("t6_pndng", {31'd0, pndng}, 32'd0);
        chk("t6_full", {31'd0, full}, 32'd0);
        chk("t6_ovf", {16'd0, overflow_cnt}, 32'd0);
        chk("t6_mis", {16'd0, misroute_cnt}, 32'd0);
        step(1'b0, 16'h0000, 1'b0);
        chk("t6_idle", {28'd0, count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
